// File: rtl/act_arbiter.sv
// Round-robin arbiter sharing one fixed-latency activation unit among NREQ requesters,
// with result routing by tag. Optional `ACT_ARB_LATCHK_EN adds a sticky tag/result alignment check.
module act_arbiter #(
    parameter int NREQ = 4,
    parameter int QZ_R = 8,
    parameter int QZ_D = 16,
    parameter int QZ   = QZ_R + QZ_D,
    parameter int LAT  = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sync_clr,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*QZ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic                 act_valid,
    output logic [QZ-1:0]        act_data,
    input  logic                 act_out_valid,
    input  logic [QZ-1:0]        act_out_data,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [QZ-1:0]        rsp_data,
    output logic                 busy,
    output logic                 err
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
    } tag_t;

    logic [IDW-1:0]  rr_ptr;
    logic [IDW-1:0]  grant_id;
    logic [IDW-1:0]  act_id;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] rsp_valid_q;
    logic            grant_hit;
    logic            clr_d;
    logic            act_valid_q;
    logic            tag_any;
    int              rr_idx;
    tag_t            tag_line [LAT];
    tag_t            tag_out;

    // NOTE: every variable gets a default before the search so no latch is inferred.
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        grant_hit = 1'b0;
        rr_idx    = 0;
        for (int k = 0; k < NREQ; k++) begin
            rr_idx = (int'(rr_ptr) + k) % NREQ;
            if (!grant_hit && req_valid[rr_idx]) begin
                grant_hit = 1'b1;
                grant_id  = IDW'(rr_idx);
            end
        end
        // Grants are blocked in the clear cycle, the cycle after it, and during reset.
        if (sync_clr || clr_d || !rst_n) begin
            grant_hit = 1'b0;
        end
        if (grant_hit) begin
            grant[grant_id] = 1'b1;
        end
    end

    assign req_ready = grant;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr      <= '0;
            clr_d       <= 1'b0;
            act_valid_q <= 1'b0;
            act_data    <= '0;
            act_id      <= '0;
        end else begin
            clr_d <= sync_clr;
            if (sync_clr) begin
                rr_ptr      <= '0;
                act_valid_q <= 1'b0;
            end else begin
                act_valid_q <= grant_hit;
                if (grant_hit) begin
                    act_data <= req_data[int'(grant_id)*QZ +: QZ];
                    act_id   <= grant_id;
                    rr_ptr   <= (int'(grant_id) == NREQ - 1) ? '0 : grant_id + 1'b1;
                end
            end
        end
    end

    // NOTE: the tag line is reset because its valid bits decide whether a result is routed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < LAT; k++) tag_line[k] <= '0;
        end else if (sync_clr) begin
            for (int k = 0; k < LAT; k++) tag_line[k] <= '0;
        end else begin
            tag_line[0] <= '{vld: act_valid_q, id: act_id};
            for (int k = 1; k < LAT; k++) tag_line[k] <= tag_line[k-1];
        end
    end

    assign tag_out = tag_line[LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= '0;
            rsp_data    <= '0;
        end else begin
            rsp_valid_q <= '0;
            if (!sync_clr && act_out_valid && tag_out.vld) begin
                rsp_valid_q[tag_out.id] <= 1'b1;
            end
            if (act_out_valid) begin
                rsp_data <= act_out_data;
            end
        end
    end

    // Strobes are masked in the clear cycle itself; the registers are cleared at its edge.
    assign act_valid = act_valid_q & ~sync_clr;
    assign rsp_valid = rsp_valid_q & {NREQ{~sync_clr}};

    always_comb begin
        tag_any = 1'b0;
        for (int k = 0; k < LAT; k++) tag_any = tag_any | tag_line[k].vld;
    end

    assign busy = act_valid | tag_any;

`ifdef ACT_ARB_LATCHK_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (sync_clr) begin
            err_q <= 1'b0;
        end else if (act_out_valid != tag_out.vld) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_act_arbiter.sv
// Scoreboard bench for act_arbiter: directed grants checked inline, results checked by a monitor.
module tb_act_arbiter;

    localparam int NREQ = 4;
    localparam int QZ   = 24;
    localparam int LAT  = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sync_clr = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ*QZ-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              act_valid;
    logic [QZ-1:0]     act_data;
    logic              act_out_valid;
    logic [QZ-1:0]     act_out_data;
    logic [NREQ-1:0]   rsp_valid;
    logic [QZ-1:0]     rsp_data;
    logic              busy;
    logic              err;

    logic [QZ-1:0] tb_d [NREQ];
    assign req_data = {tb_d[3], tb_d[2], tb_d[1], tb_d[0]};

    act_arbiter #(.NREQ(NREQ), .QZ_R(8), .QZ_D(16), .LAT(LAT)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sync_clr     (sync_clr),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .act_valid    (act_valid),
        .act_data     (act_data),
        .act_out_valid(act_out_valid),
        .act_out_data (act_out_data),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .busy         (busy),
        .err          (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Identity activation unit with adjustable latency.
    int            model_lat = LAT;
    logic          mv [8];
    logic [QZ-1:0] md [8];
    always @(posedge clk) begin
        mv[0] <= act_valid;
        md[0] <= act_data;
        for (int k = 1; k < 8; k++) begin
            mv[k] <= mv[k-1];
            md[k] <= md[k-1];
        end
    end
    assign act_out_valid = mv[model_lat-1];
    assign act_out_data  = md[model_lat-1];

    typedef struct {
        int            id;
        logic [QZ-1:0] data;
        int            due;
    } exp_t;
    exp_t exp_q [$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    logic          pend_v = 1'b0;
    logic [QZ-1:0] pend_d = '0;

    task automatic cycle(input logic [3:0] v, input logic [3:0] rdy, input logic clr, input logic push);
        int id;
        req_valid = v;
        sync_clr  = clr;
        if (clr) exp_q.delete();
        @(negedge clk);
        check("req_ready", 32'(req_ready), 32'(rdy));
        check("act_valid", 32'(act_valid), 32'(pend_v & ~clr));
        if (pend_v && !clr) check("act_data", 32'(act_data), 32'(pend_d));
        pend_v = 1'b0;
        id = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (rdy[i]) begin
                pend_v = 1'b1;
                id = i;
            end
        end
        pend_d = tb_d[id];
        if (pend_v && push) exp_q.push_back('{id, tb_d[id], cyc + LAT + 2});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(4'b0000, 4'b0000, 1'b0, 1'b1);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle();
        idle();
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Result monitor: every rsp_valid must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp_valid !== '0) begin
                if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_valid", 32'(rsp_valid), 32'd1 << e.id);
                    check("rsp_data", 32'(rsp_data), 32'(e.data));
                    check("rsp_latency", 32'(cyc), 32'(e.due));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        tb_d[0] = 24'h0A0001;
        tb_d[1] = 24'h00F0F0;
        tb_d[2] = 24'h000100;
        tb_d[3] = 24'h7FFFFF;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_act_valid", 32'(act_valid), 32'd0);
        check("rst_act_data", 32'(act_data), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        // All four requesters held valid: strict rotation from rr_ptr=0.
        for (int i = 0; i < 8; i++) cycle(4'hF, 4'(4'b0001 << (i % 4)), 1'b0, 1'b1);
        drain("drain_rotation");

        // Single request from requester 2.
        cycle(4'b0100, 4'b0100, 1'b0, 1'b1);
        drain("drain_single");

        // Back-to-back issues from requester 1.
        for (int i = 0; i < 5; i++) begin
            tb_d[1] = 24'h00F000 + 24'(i);
            cycle(4'b0010, 4'b0010, 1'b0, 1'b1);
        end
        drain("drain_b2b");

        // sync_clr with three tags in flight.
        for (int i = 0; i < 3; i++) cycle(4'b1000, 4'b1000, 1'b0, 1'b1);
        cycle(4'hF, 4'b0000, 1'b1, 1'b1);
        check("busy_clr_p1", 32'(busy), 32'd0);
        cycle(4'hF, 4'b0000, 1'b0, 1'b1);
        check("busy_clr_p2", 32'(busy), 32'd0);
        cycle(4'hF, 4'b0001, 1'b0, 1'b1);
        drain("drain_clr");

        // Asynchronous reset mid-stream.
        cycle(4'hF, 4'b0010, 1'b0, 1'b1);
        cycle(4'hF, 4'b0100, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_req_ready", 32'(req_ready), 32'd0);
        check("arst_act_valid", 32'(act_valid), 32'd0);
        check("arst_act_data", 32'(act_data), 32'd0);
        check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("arst_rsp_data", 32'(rsp_data), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_err", 32'(err), 32'd0);
        exp_q.delete();
        pend_v = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        cycle(4'hF, 4'b0001, 1'b0, 1'b1);
        drain("drain_arst");

        // Latency misalignment: the unit answers one cycle late.
        cycle(4'b0000, 4'b0000, 1'b1, 1'b0);
        idle();
        check("err_before", 32'(err), 32'd0);
        model_lat = LAT + 1;
        cycle(4'b0010, 4'b0010, 1'b0, 1'b0);
        repeat (LAT + 4) idle();
`ifdef ACT_ARB_LATCHK_EN
        check("err_set", 32'(err), 32'd1);
        repeat (3) idle();
        check("err_sticky", 32'(err), 32'd1);
`else
        check("err_tied", 32'(err), 32'd0);
        repeat (3) idle();
        check("err_tied_late", 32'(err), 32'd0);
`endif
        check("exp_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/act_arbiter.md
ACT_ARBITER -- requirements
Module: act_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing one activation unit.
REQ-002 SHALL have parameter QZ_R, default 8, integer bits of the fixed-point data.
REQ-003 SHALL have parameter QZ_D, default 16, fractional bits of the fixed-point data.
REQ-004 SHALL have parameter QZ, default QZ_R+QZ_D, data width.
REQ-005 SHALL have parameter LAT, default 5, cycles from act_valid to act_out_valid of the activation unit.
REQ-006 SHALL have port clk  input  1  single clock, rising edge.
REQ-007 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have port sync_clr  input  1  synchronous clear of arbiter state and in-flight tags.
REQ-009 SHALL have port req_valid  input  NREQ  per-requester request.
REQ-010 SHALL have port req_data  input  NREQ*QZ  packed operands, requester i at bits [i*QZ +: QZ].
REQ-011 SHALL have port req_ready  output  NREQ  one-hot grant/accept.
REQ-012 SHALL have port act_valid  output  1  issue strobe to the activation unit.
REQ-013 SHALL have port act_data  output  QZ  operand to the activation unit.
REQ-014 SHALL have port act_out_valid  input  1  result strobe from the activation unit.
REQ-015 SHALL have port act_out_data  input  QZ  result from the activation unit.
REQ-016 SHALL have port rsp_valid  output  NREQ  one-hot result strobe to the owning requester.
REQ-017 SHALL have port rsp_data  output  QZ  result data, shared by all requesters.
REQ-018 SHALL have port busy  output  1  high while any tag is in flight or act_valid is high.
REQ-019 SHALL have port err  output  1  sticky tag/result misalignment flag.

Function
REQ-020 SHALL accept a transfer on requester i when req_valid[i] and req_ready[i] are high in the same cycle.
REQ-021 SHALL drive req_ready combinationally: at most one bit high, only for a requester with req_valid high, chosen by round-robin.
REQ-022 SHALL search round-robin starting at rr_ptr; after a grant to i, rr_ptr SHALL become (i+1) mod NREQ; with no grant, rr_ptr SHALL hold.
REQ-023 SHALL accept at most one request per cycle and SHALL sustain one accept per cycle.
REQ-024 SHALL register the granted operand into act_data with act_valid=1 in the cycle after acceptance; otherwise act_valid=0 and act_data holds.
REQ-025 SHALL carry a {valid, id} tag through a LAT-stage shift line that starts on act_valid, so the tag reaches the line output together with act_out_valid.
REQ-026 SHALL, one cycle after act_out_valid, assert rsp_valid[id] for exactly one cycle and drive rsp_data with the registered act_out_data.
REQ-027 SHALL give a total latency from accept to rsp_valid of LAT+2 cycles.
REQ-028 SHALL not apply backpressure to results; requesters SHALL sample rsp_data on their rsp_valid bit.
REQ-029 SHALL give requester i starved by others a grant within NREQ cycles of req_valid[i] rising.
REQ-030 SHALL, on sync_clr, reset rr_ptr to 0, clear the tag line, and drive req_ready, act_valid and rsp_valid low in that cycle and the next; sync_clr SHALL override simultaneous requests.
REQ-031 SHALL, when act_out_valid arrives with an empty tag slot, produce no rsp_valid.
REQ-032 SHALL derive busy from act_valid OR any tag-line valid bit.

Reset
REQ-033 SHALL, while rst_n is low, asynchronously force rr_ptr=0, tag line empty, act_valid=0, act_data=0, rsp_valid=0, rsp_data=0, err=0.
REQ-034 SHALL drop in-flight operations when reset is asserted mid-operation; later unmatched act_out_valid pulses SHALL follow REQ-031.

Configuration
REQ-035 SHALL use macro ACT_ARB_LATCHK_EN: when defined, err SHALL set one cycle after any cycle where act_out_valid differs from the tag-line output valid bit, and clear only by reset or sync_clr.
REQ-036 SHALL, without ACT_ARB_LATCHK_EN, tie err to 0 and omit the check logic.

Verification
REQ-037 SHALL test single request: req_valid[2]=1, req_data=0x000100 -> req_ready[2] same cycle, act_valid next cycle with 0x000100, model returns 0x000100 after LAT -> rsp_valid=4'b0100 and rsp_data=0x000100 at accept+7.
REQ-038 SHALL test all four requesters held valid for 8 cycles -> grants 0,1,2,3,0,1,2,3 and the rsp_valid order matches the grant order.
REQ-039 SHALL test back-to-back issues: requester 1 valid for 5 consecutive cycles -> 5 consecutive act_valid pulses and 5 consecutive rsp_valid[1] pulses.
REQ-040 SHALL test sync_clr with 3 tags in flight -> no rsp_valid for those tags, busy=0 two cycles later, next grant goes to requester 0.
REQ-041 SHALL test, with ACT_ARB_LATCHK_EN defined, a model latency of LAT+1 -> err=1 and it stays set; without the macro, err=0.
REQ-042 SHALL test rst_n pulsed low mid-stream -> all outputs 0 immediately, then normal operation resumes from rr_ptr=0.
